// File: rtl/verifier_compute_w0_pkg.sv
// Field constants, FSM state encoding and modular add/sub helpers shared by the w0 datapath.
package verifier_compute_w0_pkg;

  localparam int unsigned F_NBITS = 16;
  localparam logic [F_NBITS-1:0] F_Q = 16'd65521;

  typedef enum logic [2:0] {
    IDLE,
    SUB,
    MUL_ST,
    MUL,
    ADD
  } state_t;

  // Widened sum so the carry is visible before the conditional subtract of q.
  function automatic logic [F_NBITS-1:0] mod_add(input logic [F_NBITS-1:0] a,
                                                 input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  function automatic logic [F_NBITS-1:0] mod_sub(input logic [F_NBITS-1:0] a,
                                                 input logic [F_NBITS-1:0] b);
    logic [F_NBITS-1:0] d;
    d = a - b;
    if (a < b) d = d + F_Q;
    return d;
  endfunction

endpackage

// File: rtl/field_multiplier.sv
// Bit-serial MSB-first modular multiplier: p = a*b mod q, en/ready handshake.
module field_multiplier
  import verifier_compute_w0_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic               ready,
  output logic [F_NBITS-1:0] p
);

  localparam int unsigned CNT_W = $clog2(F_NBITS);

  logic [F_NBITS-1:0] a_q;
  logic [F_NBITS-1:0] b_q;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic [F_NBITS-1:0] acc_next;

  // Double-and-add: acc = 2*acc + (bit ? a : 0), both steps reduced mod q.
  always_comb begin
    acc_next = mod_add(p, p);
    if (b_q[F_NBITS-1]) acc_next = mod_add(acc_next, a_q);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      ready <= 1'b1;
      p     <= '0;
    end else if (en && !busy) begin
      a_q   <= a;
      b_q   <= b;
      p     <= '0;
      cnt   <= CNT_W'(F_NBITS - 1);
      busy  <= 1'b1;
      ready <= 1'b0;
    end else if (busy) begin
      p   <= acc_next;
      b_q <= {b_q[F_NBITS-2:0], 1'b0};
      if (cnt == '0) begin
        busy  <= 1'b0;
        ready <= 1'b1;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/verifier_compute_w0_elem.sv
// Per-element datapath: d = w2-w1, p = d*tau, w0 = p+w1 and 1-w0, all mod q.
module verifier_compute_w0_elem
  import verifier_compute_w0_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               sub_en,
  input  logic               mul_en,
  input  logic [F_NBITS-1:0] w1,
  input  logic [F_NBITS-1:0] w2,
  input  logic [F_NBITS-1:0] tau,
  output logic               mul_ready,
  output logic [F_NBITS-1:0] w0_c,
  output logic [F_NBITS-1:0] m_w0_p1_c
);

  logic [F_NBITS-1:0] d;
  logic [F_NBITS-1:0] p;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) d <= '0;
    else if (sub_en) d <= mod_sub(w2, w1);
  end

  field_multiplier u_mul (
    .clk   (clk),
    .rstb  (rstb),
    .en    (mul_en),
    .a     (d),
    .b     (tau),
    .ready (mul_ready),
    .p     (p)
  );

  // The top registers these in its ADD cycle; w1 is still selected by the same count.
  always_comb begin
    w0_c      = mod_add(p, w1);
    m_w0_p1_c = mod_sub(F_NBITS'(1), w0_c);
  end

endmodule

// File: rtl/verifier_compute_w0.sv
// Verifier w0 step: gamma(tau) = (w2-w1)*tau + w1 and 1-gamma for every coordinate, highest index first.
module verifier_compute_w0
  import verifier_compute_w0_pkg::*;
#(
  parameter int unsigned ninbits = 3
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             en,
  input  logic [ninbits-1:0][F_NBITS-1:0]  w1,
  input  logic [ninbits-1:0][F_NBITS-1:0]  w2,
  input  logic [F_NBITS-1:0]               tau,
  output logic                             ready,
  output logic [ninbits-1:0][F_NBITS-1:0]  w0,
  output logic [ninbits-1:0][F_NBITS-1:0]  m_w0_p1
);

  localparam int unsigned CNT_W = (ninbits > 1) ? $clog2(ninbits) : 1;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               en_dly;
  logic               start;
  logic [F_NBITS-1:0] tau_q;
  logic [F_NBITS-1:0] sel_w1;
  logic [F_NBITS-1:0] sel_w2;
  logic               mul_ready;
  logic [F_NBITS-1:0] w0_c;
  logic [F_NBITS-1:0] m_w0_p1_c;

  assign start  = en & ~en_dly;
  assign ready  = (state == IDLE) & ~start;
  assign sel_w1 = w1[count];
  assign sel_w2 = w2[count];

  verifier_compute_w0_elem u_elem (
    .clk       (clk),
    .rstb      (rstb),
    .sub_en    (state == SUB),
    .mul_en    (state == MUL_ST),
    .w1        (sel_w1),
    .w2        (sel_w2),
    .tau       (tau_q),
    .mul_ready (mul_ready),
    .w0_c      (w0_c),
    .m_w0_p1_c (m_w0_p1_c)
  );

  // en_dly resets high so an en held through reset release is not seen as a rising edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      count   <= '0;
      en_dly  <= 1'b1;
      tau_q   <= '0;
      w0      <= '0;
      m_w0_p1 <= {ninbits{F_NBITS'(1)}};
    end else begin
      en_dly <= en;
      case (state)
        IDLE: begin
          if (start) begin
            tau_q <= tau;
            count <= CNT_W'(ninbits - 1);
            state <= SUB;
          end
        end
        SUB:    state <= MUL_ST;
        MUL_ST: state <= MUL;
        MUL:    if (mul_ready) state <= ADD;
        ADD: begin
          w0[count]      <= w0_c;
          m_w0_p1[count] <= m_w0_p1_c;
          if (count == '0) begin
            state <= IDLE;
          end else begin
            count <= count - CNT_W'(1);
            state <= SUB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_verifier_compute_w0.sv
// Directed bench for verifier_compute_w0 (ninbits=3 and ninbits=1 instances).
module tb_verifier_compute_w0;

  localparam logic [15:0] Q = 16'd65521;

  typedef struct {
    logic [2:0][15:0] w1;
    logic [2:0][15:0] w2;
    logic [15:0]      tau;
    logic [2:0][15:0] ew0;
    logic [2:0][15:0] em;
  } vec_t;

  logic             clk;
  logic             rstb;
  logic             en;
  logic [2:0][15:0] w1;
  logic [2:0][15:0] w2;
  logic [15:0]      tau;
  logic             ready;
  logic [2:0][15:0] w0;
  logic [2:0][15:0] m_w0_p1;

  logic             en1;
  logic [0:0][15:0] w1s;
  logic [0:0][15:0] w2s;
  logic [15:0]      taus;
  logic             ready1;
  logic [0:0][15:0] w0s;
  logic [0:0][15:0] ms;

  int checks;
  int errors;
  vec_t vecs[5];

  verifier_compute_w0 #(.ninbits(3)) dut (
    .clk(clk), .rstb(rstb), .en(en), .w1(w1), .w2(w2), .tau(tau),
    .ready(ready), .w0(w0), .m_w0_p1(m_w0_p1)
  );

  verifier_compute_w0 #(.ninbits(1)) dut1 (
    .clk(clk), .rstb(rstb), .en(en1), .w1(w1s), .w2(w2s), .tau(taus),
    .ready(ready1), .w0(w0s), .m_w0_p1(ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input bit poke);
    int n;
    n = 0;
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
      if (poke && n == 10) en = 1'b1;
      if (poke && n == 12) en = 1'b0;
    end
    chk($sformatf("%s done", tag), 16'(ready), 16'd1);
  endtask

  task automatic check_out(input vec_t v, input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s w0[%0d]", tag, i), w0[i], v.ew0[i]);
      chk($sformatf("%s m_w0_p1[%0d]", tag, i), m_w0_p1[i], v.em[i]);
    end
  endtask

  task automatic run3(input vec_t v, input string tag, input bit poke);
    @(negedge clk);
    w1 = v.w1; w2 = v.w2; tau = v.tau; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk($sformatf("%s busy", tag), 16'(ready), 16'd0);
    wait_ready(tag, poke);
    check_out(v, tag);
  endtask

  initial begin
    int hi_cnt;
    checks = 0;
    errors = 0;

    // Index 0 is the rightmost element of each packed literal.
    vecs[0] = '{w1: {16'd3, 16'd2, 16'd1}, w2: {16'd4, 16'd4, 16'd4}, tau: 16'd5,
                ew0: {16'd8, 16'd12, 16'd16}, em: {Q - 16'd7, Q - 16'd11, Q - 16'd15}};
    vecs[1] = '{w1: {16'd5, 16'd5, 16'd5}, w2: {16'd2, 16'd2, 16'd2}, tau: 16'd1,
                ew0: {16'd2, 16'd2, 16'd2}, em: {Q - 16'd1, Q - 16'd1, Q - 16'd1}};
    vecs[2] = '{w1: {16'd30, 16'd20, 16'd10}, w2: {16'd300, 16'd200, 16'd100}, tau: 16'd0,
                ew0: {16'd30, 16'd20, 16'd10}, em: {Q - 16'd29, Q - 16'd19, Q - 16'd9}};
    vecs[3] = '{w1: {16'd0, 16'd0, 16'd0}, w2: {16'd1, 16'd1, 16'd1}, tau: Q - 16'd1,
                ew0: {Q - 16'd1, Q - 16'd1, Q - 16'd1}, em: {16'd2, 16'd2, 16'd2}};
    vecs[4] = '{w1: {16'd0, 16'd7, Q - 16'd1}, w2: {Q - 16'd1, 16'd7, 16'd0}, tau: 16'd2,
                ew0: {Q - 16'd2, 16'd7, 16'd1}, em: {16'd3, Q - 16'd6, 16'd0}};

    rstb = 1'b0; en = 1'b1; en1 = 1'b0;
    w1 = '0; w2 = '0; tau = '0; w1s = '0; w2s = '0; taus = '0;
    repeat (3) @(negedge clk);
    chk("reset ready", 16'(ready), 16'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset w0[%0d]", i), w0[i], 16'd0);
      chk($sformatf("reset m_w0_p1[%0d]", i), m_w0_p1[i], 16'd1);
    end

    // en held high across reset release must not start a run.
    w1 = vecs[0].w1; w2 = vecs[0].w2; tau = vecs[0].tau;
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    chk("en-held ready", 16'(ready), 16'd1);
    chk("en-held w0[0]", w0[0], 16'd0);
    en = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) run3(vecs[k], $sformatf("vec%0d", k), 1'b0);

    // en re-pulsed while busy: exactly one run, no queued restart afterwards.
    run3(vecs[0], "poke", 1'b1);
    hi_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (ready) hi_cnt++;
    end
    chk("poke no restart", 16'(hi_cnt), 16'd60);

    // Reset during element 1's multiply discards partial results.
    @(negedge clk);
    w1 = vecs[4].w1; w2 = vecs[4].w2; tau = vecs[4].tau; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (24) @(negedge clk);
    chk("midrun busy", 16'(ready), 16'd0);
    chk("midrun w0[2] updated", w0[2], vecs[4].ew0[2]);
    rstb = 1'b0;
    #1;
    chk("midrun rst ready", 16'(ready), 16'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrun rst w0[%0d]", i), w0[i], 16'd0);
      chk($sformatf("midrun rst m[%0d]", i), m_w0_p1[i], 16'd1);
    end
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    run3(vecs[4], "rerun", 1'b0);

    // Single-coordinate build.
    @(negedge clk);
    w1s[0] = 16'd7; w2s[0] = 16'd9; taus = 16'd3; en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    chk("n1 busy", 16'(ready1), 16'd0);
    begin
      int n;
      n = 0;
      while (!ready1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("n1 done", 16'(ready1), 16'd1);
    chk("n1 w0", w0s[0], 16'd13);
    chk("n1 m_w0_p1", ms[0], Q - 16'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
